// File: rtl/rollback_sequencer.sv
// rollback_sequencer: per-thread rollback arbitration (BC > L1D > SPM), flush window and serialised trap reports.
// Optional feature macro: ROLLBACK_DROP_COUNT_EN adds saturating per-thread drop counters on port drop_count.
module rollback_sequencer #(
   parameter int THREAD_NUMB    = 4,
   parameter int ADDR_W         = 32,
   parameter int REG_W          = 32,
   parameter int FLUSH_CYCLES   = 4,
   parameter int DROP_CNT_WIDTH = 16,
   localparam int TID_W         = (THREAD_NUMB > 1) ? $clog2(THREAD_NUMB) : 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               enable,
   input  logic                               bc_rollback_en,
   input  logic [ADDR_W-1:0]                  bc_rollback_pc,
   input  logic [TID_W-1:0]                   bc_rollback_thread_id,
   input  logic                               l1d_rollback_en,
   input  logic [REG_W-1:0]                   l1d_rollback_pc,
   input  logic [TID_W-1:0]                   l1d_rollback_thread_id,
   input  logic                               spm_rollback_en,
   input  logic [REG_W-1:0]                   spm_rollback_pc,
   input  logic [TID_W-1:0]                   spm_rollback_thread_id,
   output logic [THREAD_NUMB-1:0]             rollback_valid,
   output logic [THREAD_NUMB-1:0][ADDR_W-1:0] rollback_pc_value,
   output logic [THREAD_NUMB-1:0]             thread_flushing,
   output logic [THREAD_NUMB-1:0]             rollback_dropped,
   output logic                               rollback_trap_en,
   output logic [TID_W-1:0]                   rollback_thread_id,
   output logic [REG_W-1:0]                   rollback_trap_reason
`ifdef ROLLBACK_DROP_COUNT_EN
   ,
   output logic [THREAD_NUMB-1:0][DROP_CNT_WIDTH-1:0] drop_count
`endif
);

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [REG_W-1:0] LDST_ADDR_MISALIGN = REG_W'(4);
   localparam logic [REG_W-1:0] SPM_ADDR_MISALIGN  = REG_W'(5);

   typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

   state_t                             state_q [THREAD_NUMB];
   state_t                             state_d [THREAD_NUMB];
   logic [CNT_W-1:0]                   cnt_q   [THREAD_NUMB];
   logic [CNT_W-1:0]                   cnt_d   [THREAD_NUMB];
   logic [THREAD_NUMB-1:0][ADDR_W-1:0] pc_q, pc_d;
   logic [THREAD_NUMB-1:0]             valid_q, valid_d;
   logic [THREAD_NUMB-1:0]             drop_q, drop_d;
   logic                               trap_en_q, trap_en_d;
   logic [TID_W-1:0]                   trap_tid_q, trap_tid_d;
   logic [REG_W-1:0]                   trap_reason_q, trap_reason_d;
   logic                               pend_vld_q, pend_vld_d;
   logic [TID_W-1:0]                   pend_tid_q, pend_tid_d;
   logic [REG_W-1:0]                   pend_reason_q, pend_reason_d;

   logic [THREAD_NUMB-1:0]             cand_bc, cand_l1d, cand_spm;
   logic                               l1d_ev, spm_ev;
   logic [TID_W-1:0]                   l1d_ev_tid, spm_ev_tid;

   function automatic logic [ADDR_W-1:0] fit_pc(input logic [REG_W-1:0] v);
      return ADDR_W'(v);
   endfunction

   always_comb begin
      cand_bc  = '0;
      cand_l1d = '0;
      cand_spm = '0;
      for (int t = 0; t < THREAD_NUMB; t++) begin
         cand_bc[t]  = bc_rollback_en  && (bc_rollback_thread_id  == TID_W'(t));
         cand_l1d[t] = l1d_rollback_en && (l1d_rollback_thread_id == TID_W'(t));
         cand_spm[t] = spm_rollback_en && (spm_rollback_thread_id == TID_W'(t));
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc_d          = pc_q;
      valid_d       = '0;
      drop_d        = '0;
      l1d_ev        = 1'b0;
      l1d_ev_tid    = '0;
      spm_ev        = 1'b0;
      spm_ev_tid    = '0;
      trap_en_d     = 1'b0;
      trap_tid_d    = '0;
      trap_reason_d = '0;
      pend_vld_d    = pend_vld_q;
      pend_tid_d    = pend_tid_q;
      pend_reason_d = pend_reason_q;

      if (enable) begin
         for (int t = 0; t < THREAD_NUMB; t++) begin
            if (state_q[t] == IDLE) begin
               if (cand_bc[t] || cand_l1d[t] || cand_spm[t]) begin
                  valid_d[t] = 1'b1;
                  state_d[t] = FLUSH;
                  cnt_d[t]   = CNT_W'(FLUSH_CYCLES - 1);
                  drop_d[t]  = (cand_bc[t] && cand_l1d[t]) || (cand_bc[t] && cand_spm[t]) ||
                               (cand_l1d[t] && cand_spm[t]);
                  if (cand_bc[t]) begin
                     pc_d[t] = bc_rollback_pc;
                  end else if (cand_l1d[t]) begin
                     pc_d[t]    = fit_pc(l1d_rollback_pc);
                     l1d_ev     = 1'b1;
                     l1d_ev_tid = TID_W'(t);
                  end else begin
                     pc_d[t]    = fit_pc(spm_rollback_pc);
                     spm_ev     = 1'b1;
                     spm_ev_tid = TID_W'(t);
                  end
               end
            end else begin
               // Requests from instructions already being flushed are stale.
               drop_d[t] = cand_bc[t] || cand_l1d[t] || cand_spm[t];
               if (cnt_q[t] == '0) begin
                  state_d[t] = IDLE;
               end else begin
                  cnt_d[t] = cnt_q[t] - CNT_W'(1);
               end
            end
         end

         // Pending entry reports first; at most one new event can be parked behind it.
         if (pend_vld_q) begin
            trap_en_d     = 1'b1;
            trap_tid_d    = pend_tid_q;
            trap_reason_d = pend_reason_q;
            pend_vld_d    = l1d_ev || spm_ev;
            if (l1d_ev) begin
               pend_tid_d    = l1d_ev_tid;
               pend_reason_d = LDST_ADDR_MISALIGN;
               if (spm_ev) begin
                  drop_d[spm_ev_tid] = 1'b1;
               end
            end else if (spm_ev) begin
               pend_tid_d    = spm_ev_tid;
               pend_reason_d = SPM_ADDR_MISALIGN;
            end
         end else if (l1d_ev) begin
            trap_en_d     = 1'b1;
            trap_tid_d    = l1d_ev_tid;
            trap_reason_d = LDST_ADDR_MISALIGN;
            pend_vld_d    = spm_ev;
            pend_tid_d    = spm_ev_tid;
            pend_reason_d = SPM_ADDR_MISALIGN;
         end else if (spm_ev) begin
            trap_en_d     = 1'b1;
            trap_tid_d    = spm_ev_tid;
            trap_reason_d = SPM_ADDR_MISALIGN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int t = 0; t < THREAD_NUMB; t++) begin
            state_q[t] <= IDLE;
            cnt_q[t]   <= '0;
         end
         pc_q          <= '0;
         valid_q       <= '0;
         drop_q        <= '0;
         trap_en_q     <= 1'b0;
         trap_tid_q    <= '0;
         trap_reason_q <= '0;
         pend_vld_q    <= 1'b0;
         pend_tid_q    <= '0;
         pend_reason_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pc_q          <= pc_d;
         valid_q       <= valid_d;
         drop_q        <= drop_d;
         trap_en_q     <= trap_en_d;
         trap_tid_q    <= trap_tid_d;
         trap_reason_q <= trap_reason_d;
         pend_vld_q    <= pend_vld_d;
         pend_tid_q    <= pend_tid_d;
         pend_reason_q <= pend_reason_d;
      end
   end

   always_comb begin
      thread_flushing = '0;
      for (int t = 0; t < THREAD_NUMB; t++) begin
         thread_flushing[t] = (state_q[t] == FLUSH);
      end
   end

   assign rollback_valid       = valid_q;
   assign rollback_pc_value    = pc_q;
   assign rollback_dropped     = drop_q;
   assign rollback_trap_en     = trap_en_q;
   assign rollback_thread_id   = trap_tid_q;
   assign rollback_trap_reason = trap_reason_q;

`ifdef ROLLBACK_DROP_COUNT_EN
   logic [THREAD_NUMB-1:0][DROP_CNT_WIDTH-1:0] drop_cnt_q;

   // Counted on the same edge that raises rollback_dropped, so stalls never lose a drop.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_q <= '0;
      end else begin
         for (int t = 0; t < THREAD_NUMB; t++) begin
            if (drop_d[t] && (drop_cnt_q[t] != '1)) begin
               drop_cnt_q[t] <= drop_cnt_q[t] + DROP_CNT_WIDTH'(1);
            end
         end
      end
   end

   assign drop_count = drop_cnt_q;
`else
   // Drop counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_rollback_sequencer.sv
// Self-checking bench for rollback_sequencer: vector table, directed multi-cycle sequences, random vs. reference model.
module tb_rollback_sequencer;
   localparam int TN = 4;
   localparam int AW = 32;
   localparam int RW = 32;
   localparam int FC = 4;
   localparam logic [RW-1:0] R_LDST = 32'd4;
   localparam logic [RW-1:0] R_SPM  = 32'd5;

   logic                   clk = 1'b0;
   logic                   reset, enable;
   logic                   bc_en, l1d_en, spm_en;
   logic [AW-1:0]          bc_pc;
   logic [RW-1:0]          l1d_pc, spm_pc;
   logic [1:0]             bc_tid, l1d_tid, spm_tid;
   logic [TN-1:0]          rollback_valid, thread_flushing, rollback_dropped;
   logic [TN-1:0][AW-1:0]  rollback_pc_value;
   logic                   rollback_trap_en;
   logic [1:0]             rollback_thread_id;
   logic [RW-1:0]          rollback_trap_reason;
`ifdef ROLLBACK_DROP_COUNT_EN
   logic [TN-1:0][15:0]    drop_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rollback_sequencer #(
      .THREAD_NUMB(TN), .ADDR_W(AW), .REG_W(RW), .FLUSH_CYCLES(FC), .DROP_CNT_WIDTH(16)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .bc_rollback_en(bc_en), .bc_rollback_pc(bc_pc), .bc_rollback_thread_id(bc_tid),
      .l1d_rollback_en(l1d_en), .l1d_rollback_pc(l1d_pc), .l1d_rollback_thread_id(l1d_tid),
      .spm_rollback_en(spm_en), .spm_rollback_pc(spm_pc), .spm_rollback_thread_id(spm_tid),
      .rollback_valid(rollback_valid), .rollback_pc_value(rollback_pc_value),
      .thread_flushing(thread_flushing), .rollback_dropped(rollback_dropped),
      .rollback_trap_en(rollback_trap_en), .rollback_thread_id(rollback_thread_id),
      .rollback_trap_reason(rollback_trap_reason)
`ifdef ROLLBACK_DROP_COUNT_EN
      , .drop_count(drop_count)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic be, input logic [1:0] bt, input logic [31:0] bp,
                        input logic le, input logic [1:0] lt, input logic [31:0] lp,
                        input logic se, input logic [1:0] st, input logic [31:0] sp);
      bc_en = be;  bc_tid = bt;  bc_pc = bp;
      l1d_en = le; l1d_tid = lt; l1d_pc = lp;
      spm_en = se; spm_tid = st; spm_pc = sp;
   endtask

   task automatic clr();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      clr();
      reset = 1'b1;
      enable = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Reference model: remaining flush cycles per thread and a queue of waiting trap reports.
   typedef struct {logic [1:0] tid; logic [31:0] reason;} tr_t;
   int            rem [TN];
   logic [31:0]   m_pc [TN];
   tr_t           m_pend[$];
   logic [TN-1:0] e_valid, e_drop;
   logic          e_trap;
   logic [1:0]    e_tid;
   logic [31:0]   e_reason;

   task automatic model_step();
      tr_t all[$];
      tr_t l1ev[$];
      tr_t spev[$];
      e_valid = '0; e_drop = '0; e_trap = 0; e_tid = 0; e_reason = 0;
      if (reset) begin
         for (int t = 0; t < TN; t++) begin rem[t] = 0; m_pc[t] = 0; end
         m_pend.delete();
         return;
      end
      if (!enable) return;
      for (int t = 0; t < TN; t++) begin
         int n = 0;
         int src = -1;
         logic [31:0] wpc = 0;
         if (bc_en  && bc_tid  == 2'(t)) begin n++; if (src < 0) begin src = 0; wpc = bc_pc;  end end
         if (l1d_en && l1d_tid == 2'(t)) begin n++; if (src < 0) begin src = 1; wpc = l1d_pc; end end
         if (spm_en && spm_tid == 2'(t)) begin n++; if (src < 0) begin src = 2; wpc = spm_pc; end end
         if (rem[t] == 0) begin
            if (n > 0) begin
               e_valid[t] = 1; m_pc[t] = wpc; rem[t] = FC;
               if (n > 1) e_drop[t] = 1;
               if (src == 1) l1ev.push_back('{2'(t), R_LDST});
               if (src == 2) spev.push_back('{2'(t), R_SPM});
            end
         end else begin
            rem[t]--;
            if (n > 0) e_drop[t] = 1;
         end
      end
      all = {m_pend, l1ev, spev};
      m_pend.delete();
      if (all.size() > 0) begin e_trap = 1; e_tid = all[0].tid; e_reason = all[0].reason; end
      if (all.size() > 1) m_pend.push_back(all[1]);
      if (all.size() > 2) e_drop[all[2].tid] = 1;
   endtask

   typedef struct {
      logic bc; logic [1:0] bt; logic l1; logic [1:0] lt; logic sp; logic [1:0] st;
      logic [3:0] ev; logic [3:0] ed; logic et; logic [1:0] ett; logic [31:0] etr;
      logic [1:0] ptid; logic [31:0] epc;
   } vec_t;
   vec_t vecs[10];

   initial begin
      vecs[0] = '{1, 1, 0, 0, 0, 0, 4'b0010, 4'b0000, 0, 0, 0,      1, 32'h1000};
      vecs[1] = '{1, 0, 1, 0, 0, 0, 4'b0001, 4'b0001, 0, 0, 0,      0, 32'h1000};
      vecs[2] = '{0, 0, 1, 2, 0, 0, 4'b0100, 4'b0000, 1, 2, R_LDST, 2, 32'h2000};
      vecs[3] = '{0, 0, 0, 0, 1, 3, 4'b1000, 4'b0000, 1, 3, R_SPM,  3, 32'h3000};
      vecs[4] = '{0, 0, 1, 1, 1, 1, 4'b0010, 4'b0010, 1, 1, R_LDST, 1, 32'h2000};
      vecs[5] = '{1, 2, 1, 2, 1, 2, 4'b0100, 4'b0100, 0, 0, 0,      2, 32'h1000};
      vecs[6] = '{0, 0, 1, 0, 1, 2, 4'b0101, 4'b0000, 1, 0, R_LDST, 2, 32'h3000};
      vecs[7] = '{1, 3, 0, 0, 1, 0, 4'b1001, 4'b0000, 1, 0, R_SPM,  3, 32'h1000};
      vecs[8] = '{1, 1, 0, 0, 1, 3, 4'b1010, 4'b0000, 1, 3, R_SPM,  1, 32'h1000};
      vecs[9] = '{0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0,      0, 32'h0};

      reset = 1'b1; enable = 1'b1; clr();
      tick(); tick();
      reset = 1'b0;
      chk("reset_valid", rollback_valid, 0);
      chk("reset_flush", thread_flushing, 0);
      chk("reset_drop", rollback_dropped, 0);
      chk("reset_trap", {rollback_trap_en, rollback_thread_id, rollback_trap_reason}, 0);
      chk("reset_pc", rollback_pc_value, 0);

      // Single-cycle vectors from a clean state.
      for (int i = 0; i < 10; i++) begin
         do_reset();
         drive(vecs[i].bc, vecs[i].bt, 32'h1000, vecs[i].l1, vecs[i].lt, 32'h2000,
               vecs[i].sp, vecs[i].st, 32'h3000);
         tick();
         clr();
         chk($sformatf("vec%0d_valid", i), rollback_valid, vecs[i].ev);
         chk($sformatf("vec%0d_flush", i), thread_flushing, vecs[i].ev);
         chk($sformatf("vec%0d_drop", i), rollback_dropped, vecs[i].ed);
         chk($sformatf("vec%0d_trap", i), {rollback_trap_en, rollback_thread_id, rollback_trap_reason},
             {vecs[i].et, vecs[i].ett, vecs[i].etr});
         chk($sformatf("vec%0d_pc", i), rollback_pc_value[vecs[i].ptid], vecs[i].epc);
      end

      // BC rollback, thread 1: one-cycle valid, four-cycle flush window.
      do_reset();
      drive(1, 1, 32'h400, 0, 0, 0, 0, 0, 0);
      tick();
      clr();
      chk("seqA_valid", rollback_valid, 4'b0010);
      chk("seqA_pc", rollback_pc_value[1], 32'h400);
      chk("seqA_flush1", thread_flushing, 4'b0010);
      for (int i = 2; i <= 5; i++) begin
         tick();
         chk($sformatf("seqA_valid%0d", i), rollback_valid, 0);
         chk($sformatf("seqA_flush%0d", i), thread_flushing, (i <= FC) ? 4'b0010 : 4'b0000);
      end

      // Simultaneous traps on two threads are reported one after the other.
      do_reset();
      drive(0, 0, 0, 1, 0, 32'h2000, 1, 2, 32'h3000);
      tick();
      clr();
      chk("seqB_trap1", {rollback_trap_en, rollback_thread_id, rollback_trap_reason}, {1'b1, 2'd0, R_LDST});
      tick();
      chk("seqB_trap2", {rollback_trap_en, rollback_thread_id, rollback_trap_reason}, {1'b1, 2'd2, R_SPM});
      tick();
      chk("seqB_trap3", {rollback_trap_en, rollback_thread_id, rollback_trap_reason}, 0);

      // Second request inside the window is dropped; window is not restarted.
      do_reset();
      drive(1, 3, 32'hA0, 0, 0, 0, 0, 0, 0);
      tick();
      clr();
      chk("seqC_valid0", rollback_valid, 4'b1000);
      tick();
      drive(1, 3, 32'hB0, 0, 0, 0, 0, 0, 0);
      tick();
      clr();
      chk("seqC_drop", {rollback_valid, rollback_dropped, thread_flushing}, {4'b0000, 4'b1000, 4'b1000});
      tick();
      chk("seqC_flush4", {rollback_dropped, thread_flushing}, {4'b0000, 4'b1000});
      tick();
      chk("seqC_flush5", thread_flushing, 0);
      drive(1, 3, 32'hC0, 0, 0, 0, 0, 0, 0);
      tick();
      clr();
      chk("seqC_valid5", rollback_valid, 4'b1000);
      chk("seqC_pc5", rollback_pc_value[3], 32'hC0);

      // Stall of three cycles mid-flush stretches the window; requests during the stall are ignored.
      do_reset();
      drive(1, 0, 32'h50, 0, 0, 0, 0, 0, 0);
      tick();
      clr();
      tick();
      enable = 1'b0;
      drive(1, 1, 32'h60, 1, 0, 32'h70, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("seqD_stall%0d", i), {rollback_valid, rollback_dropped, thread_flushing},
             {4'b0000, 4'b0000, 4'b0001});
      end
      enable = 1'b1;
      clr();
      for (int i = 0; i < 2; i++) begin
         tick();
         chk($sformatf("seqD_flush%0d", i), thread_flushing, 4'b0001);
      end
      tick();
      chk("seqD_end", thread_flushing, 0);

      // Reset while flushing with a trap parked in the pending buffer.
      do_reset();
      drive(0, 0, 0, 1, 0, 32'h2000, 1, 2, 32'h3000);
      tick();
      clr();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("seqE_all", {rollback_valid, thread_flushing, rollback_dropped, rollback_trap_en,
                       rollback_thread_id, rollback_trap_reason}, 0);
      chk("seqE_pc", rollback_pc_value, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("seqE_notrap%0d", i), {rollback_trap_en, thread_flushing}, 0);
      end

      // Random traffic against the reference model.
      reset = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (i > 0) reset = ($urandom_range(0, 199) == 0);
         enable = ($urandom_range(0, 9) != 0);
         drive($urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)), $urandom,
               $urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)), $urandom,
               $urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)), $urandom);
         model_step();
         tick();
         chk("rnd_valid", rollback_valid, e_valid);
         chk("rnd_drop", rollback_dropped, e_drop);
         chk("rnd_trap", {rollback_trap_en, rollback_thread_id, rollback_trap_reason}, {e_trap, e_tid, e_reason});
         for (int t = 0; t < TN; t++) begin
            chk($sformatf("rnd_flush%0d", t), thread_flushing[t], rem[t] > 0);
            chk($sformatf("rnd_pc%0d", t), rollback_pc_value[t], m_pc[t]);
         end
      end

`ifdef ROLLBACK_DROP_COUNT_EN
      do_reset();
      chk("cnt_reset", drop_count, 0);
      drive(1, 0, 32'h10, 1, 0, 32'h20, 0, 0, 0);
      repeat (70000) tick();
      clr();
      tick();
      chk("cnt_sat", drop_count[0], 16'hFFFF);
      chk("cnt_other", drop_count[1], 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
